// File: rtl/prim_subreg_shadow_if.sv
// Bus bundle for one shadowed register slice: software/hardware write side
// plus the committed value and error flags going back out.
interface prim_subreg_shadow_if #(
    parameter int DW = 32
);
    logic          re;
    logic          we;
    logic [DW-1:0] wd;
    logic          de;
    logic [DW-1:0] d;
    logic          qe;
    logic [DW-1:0] q;
    logic [DW-1:0] qs;
    logic          phase;
    logic          err_update;
    logic          err_storage;

    modport master (
        output re, we, wd, de, d,
        input  qe, q, qs, phase, err_update, err_storage
    );

    modport slave (
        input  re, we, wd, de, d,
        output qe, q, qs, phase, err_update, err_storage
    );
endinterface

// File: rtl/prim_subreg_shadow.sv
// Shadowed CSR slice: a value commits only after two identical software writes,
// and is stored as a true/inverted pair so storage corruption is detectable.
module prim_subreg_shadow #(
    parameter int            DW       = 32,
    parameter string         SWACCESS = "RW",
    parameter logic [DW-1:0] RESVAL   = '0
) (
    input logic                 clk_i,
    input logic                 rst_ni,
    prim_subreg_shadow_if.slave bus
);
    localparam int unsigned MODE = (SWACCESS == "RW" || SWACCESS == "WO") ? 0 :
                                   (SWACCESS == "W1S") ? 1 :
                                   (SWACCESS == "W1C") ? 2 :
                                   (SWACCESS == "W0C") ? 3 : 4;

    generate
        if (MODE == 4) begin : g_bad_swaccess
            $error("prim_subreg_shadow: unsupported SWACCESS value");
        end
    endgenerate

    logic [DW-1:0] staged_q, staged_d;
    logic [DW-1:0] q_q, q_d;
    logic [DW-1:0] shadow_q, shadow_d;
    logic          phase_q, phase_d;
    logic          qe_q, qe_d;
    logic          err_q, err_d;
    logic [DW-1:0] base, wv;
    logic          wr_first, wr_confirm, commit;

    // Hardware data forms the base when both ports are active, so software bits win.
    assign base = bus.de ? bus.d : q_q;

    always_comb begin
        wv = bus.wd;
        case (MODE)
            1:       wv = base | bus.wd;
            2:       wv = base & ~bus.wd;
            3:       wv = base & bus.wd;
            default: wv = bus.wd;
        endcase
    end

    assign wr_first   = bus.we && !bus.re && !phase_q;
    assign wr_confirm = bus.we && !bus.re && phase_q;
    assign commit     = wr_confirm && (bus.wd == staged_q);

    always_comb begin
        phase_d  = phase_q;
        staged_d = staged_q;
        q_d      = q_q;
        shadow_d = shadow_q;
        qe_d     = commit;
        err_d    = wr_confirm && !commit;

        if (wr_first) begin
            phase_d  = 1'b1;
            staged_d = bus.wd;
        end else if (bus.re || wr_confirm) begin
            phase_d = 1'b0;
        end

        if (commit) begin
            q_d      = wv;
            shadow_d = ~wv;
        end else if (bus.de) begin
            q_d      = bus.d;
            shadow_d = ~bus.d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            staged_q <= '0;
            phase_q  <= 1'b0;
            q_q      <= RESVAL;
            shadow_q <= ~RESVAL;
            qe_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            staged_q <= staged_d;
            phase_q  <= phase_d;
            q_q      <= q_d;
            shadow_q <= shadow_d;
            qe_q     <= qe_d;
            err_q    <= err_d;
        end
    end

    assign bus.q           = q_q;
    assign bus.qs          = q_q;
    assign bus.phase       = phase_q;
    assign bus.qe          = qe_q;
    assign bus.err_update  = err_q;
    assign bus.err_storage = (q_q != ~shadow_q);
endmodule

// File: tb/tb_prim_subreg_shadow.sv
// Randomized and directed bench for two shadowed slices (RW/0x00 and W1C/0xFF)
// compared every cycle against a transaction-level model of the register.
module tb_prim_subreg_shadow;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    prim_subreg_shadow_if #(.DW(8)) if_rw ();
    prim_subreg_shadow_if #(.DW(8)) if_wc ();

    logic       s_re [2];
    logic       s_we [2];
    logic [7:0] s_wd [2];
    logic       s_de [2];
    logic [7:0] s_d  [2];

    assign if_rw.re = s_re[0];
    assign if_rw.we = s_we[0];
    assign if_rw.wd = s_wd[0];
    assign if_rw.de = s_de[0];
    assign if_rw.d  = s_d[0];
    assign if_wc.re = s_re[1];
    assign if_wc.we = s_we[1];
    assign if_wc.wd = s_wd[1];
    assign if_wc.de = s_de[1];
    assign if_wc.d  = s_d[1];

    prim_subreg_shadow #(.DW(8), .SWACCESS("RW"), .RESVAL(8'h00)) dut_rw (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_rw));
    prim_subreg_shadow #(.DW(8), .SWACCESS("W1C"), .RESVAL(8'hFF)) dut_wc (
        .clk_i(clk), .rst_ni(rst_n), .bus(if_wc));

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // Reference model: committed value, pending staged value, whether a
    // confirming write is awaited, and last-cycle event flags.
    logic [7:0] m_q   [2];
    logic [7:0] m_stg [2];
    bit         m_ph  [2];
    bit         m_qe  [2];
    bit         m_err [2];
    bit         skip_es [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_q[k]   = (k == 0) ? 8'h00 : 8'hFF;
                m_stg[k] = 8'h00;
                m_ph[k]  = 1'b0;
                m_qe[k]  = 1'b0;
                m_err[k] = 1'b0;
            end else begin
                logic [7:0] basev;
                bit         committed;
                committed = 1'b0;
                m_err[k]  = 1'b0;
                if (s_re[k]) begin
                    m_ph[k] = 1'b0;
                end else if (s_we[k]) begin
                    if (!m_ph[k]) begin
                        m_stg[k] = s_wd[k];
                        m_ph[k]  = 1'b1;
                    end else begin
                        m_ph[k] = 1'b0;
                        if (s_wd[k] == m_stg[k]) begin
                            basev     = s_de[k] ? s_d[k] : m_q[k];
                            m_q[k]    = (k == 0) ? s_wd[k] : (basev & ~s_wd[k]);
                            committed = 1'b1;
                        end else begin
                            m_err[k] = 1'b1;
                        end
                    end
                end
                if (s_de[k] && !committed) m_q[k] = s_d[k];
                if (committed || s_de[k]) skip_es[k] = 1'b0;
                m_qe[k] = committed;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rw.q",  if_rw.q,  m_q[0]);
            chk("rw.qs", if_rw.qs, m_q[0]);
            chk("rw.phase", if_rw.phase, m_ph[0]);
            chk("rw.qe", if_rw.qe, m_qe[0]);
            chk("rw.err_update", if_rw.err_update, m_err[0]);
            if (!skip_es[0]) chk("rw.err_storage", if_rw.err_storage, 0);
            chk("wc.q",  if_wc.q,  m_q[1]);
            chk("wc.qs", if_wc.qs, m_q[1]);
            chk("wc.phase", if_wc.phase, m_ph[1]);
            chk("wc.qe", if_wc.qe, m_qe[1]);
            chk("wc.err_update", if_wc.err_update, m_err[1]);
            if (!skip_es[1]) chk("wc.err_storage", if_wc.err_storage, 0);
        end
    end

    task automatic idle();
        for (int k = 0; k < 2; k++) begin
            s_re[k] = 1'b0; s_we[k] = 1'b0; s_wd[k] = 8'h00;
            s_de[k] = 1'b0; s_d[k]  = 8'h00;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int k, input logic [7:0] v);
        s_we[k] = 1'b1;
        s_wd[k] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [7:0] fv;

    initial begin
        skip_es[0] = 1'b0;
        skip_es[1] = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("reset rw.q", if_rw.q, 8'h00);
        chk("reset rw.qs", if_rw.qs, 8'h00);
        chk("reset rw.phase", if_rw.phase, 0);
        chk("reset rw.qe", if_rw.qe, 0);
        chk("reset rw.err_update", if_rw.err_update, 0);
        chk("reset rw.err_storage", if_rw.err_storage, 0);
        chk("reset wc.q", if_wc.q, 8'hFF);
        chk("reset wc.qs", if_wc.qs, 8'hFF);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        tick();

        // Mismatched confirm
        wr(0, 8'h5A); tick();
        chk("mis phase1", if_rw.phase, 1);
        idle(); wr(0, 8'h3C); tick(); idle();
        chk("mis err_update", if_rw.err_update, 1);
        chk("mis q", if_rw.q, 8'h00);
        chk("mis phase0", if_rw.phase, 0);
        tick();
        chk("mis err_update drop", if_rw.err_update, 0);

        // Matching double write
        wr(0, 8'h5A); tick();
        chk("dbl phase1", if_rw.phase, 1);
        chk("dbl q before", if_rw.q, 8'h00);
        idle(); wr(0, 8'h5A); tick(); idle();
        chk("dbl q", if_rw.q, 8'h5A);
        chk("dbl qe", if_rw.qe, 1);
        tick();
        chk("dbl qe drop", if_rw.qe, 0);

        // Read between writes restarts the sequence
        wr(0, 8'h5A); tick(); idle();
        s_re[0] = 1'b1; tick(); idle();
        chk("re phase0", if_rw.phase, 0);
        wr(0, 8'h3C); tick(); idle();
        chk("re staged phase1", if_rw.phase, 1);
        chk("re no err", if_rw.err_update, 0);
        chk("re q kept", if_rw.q, 8'h5A);
        s_re[0] = 1'b1; tick(); idle();

        // W1C
        wr(1, 8'h0F); tick(); wr(1, 8'h0F); tick(); idle();
        chk("w1c q", if_wc.q, 8'hF0);
        s_de[1] = 1'b1; s_d[1] = 8'hFF; tick(); idle();
        chk("w1c hw restore", if_wc.q, 8'hFF);
        wr(1, 8'h0F); tick();
        wr(1, 8'h0F); s_de[1] = 1'b1; s_d[1] = 8'hFF; tick(); idle();
        chk("w1c de+commit q", if_wc.q, 8'hF0);
        chk("w1c de+commit qe", if_wc.qe, 1);
        s_de[1] = 1'b1; s_d[1] = 8'h81; tick(); idle();
        chk("w1c hw q", if_wc.q, 8'h81);
        chk("w1c hw qe", if_wc.qe, 0);
        chk("w1c hw phase", if_wc.phase, 0);

        // Storage fault injection
        fv = ~m_q[0] ^ 8'h01;
        skip_es[0] = 1'b1;
        force dut_rw.shadow_q = fv;
        #1;
        chk("fault err_storage", if_rw.err_storage, 1);
        release dut_rw.shadow_q;
        wr(0, 8'h11); tick(); wr(0, 8'h11); tick(); idle();
        chk("fault cleared", if_rw.err_storage, 0);
        chk("fault q", if_rw.q, 8'h11);

        // Reset while a confirm is pending
        wr(0, 8'h77); wr(1, 8'h33); tick(); idle();
        chk("midrst phase1", if_rw.phase, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst rw.q", if_rw.q, 8'h00);
        chk("midrst rw.phase", if_rw.phase, 0);
        chk("midrst wc.q", if_wc.q, 8'hFF);
        chk("midrst wc.phase", if_wc.phase, 0);
        #2 rst_n = 1'b1;
        wr(0, 8'h42); tick(); idle();
        chk("postrst q", if_rw.q, 8'h00);
        chk("postrst phase", if_rw.phase, 1);
        s_re[0] = 1'b1; tick(); idle();

        // Random traffic
        repeat (3000) begin
            for (int k = 0; k < 2; k++) begin
                s_re[k] = ($urandom_range(0, 7) == 0);
                s_we[k] = $urandom_range(0, 1);
                s_wd[k] = ($urandom_range(0, 2) != 0) ? m_stg[k] : 8'($urandom);
                s_de[k] = ($urandom_range(0, 4) == 0);
                s_d[k]  = 8'($urandom);
            end
            tick();
        end
        idle();
        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
